mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter that shares one memory access port
// among several valid/ready requesters. One access is in flight at a time, and
// a watchdog turns a stalled access into an error completion.
module mem_port_arbiter #(
    parameter int req_num        = 4,
    parameter int abits          = 48,
    parameter int dbits          = 64,
    parameter int timeout_cycles = 1023
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [req_num-1:0]         i_req_valid,
    input  logic [req_num-1:0]         i_req_write,
    input  logic [req_num*abits-1:0]   i_req_addr,
    input  logic [req_num*dbits-1:0]   i_req_wdata,
    input  logic [req_num*dbits/8-1:0] i_req_wstrb,
    output logic [req_num-1:0]         o_req_ready,
    output logic [req_num-1:0]         o_resp_valid,
    output logic [dbits-1:0]           o_resp_rdata,
    output logic                       o_resp_err,
    output logic                       o_mem_valid,
    output logic                       o_mem_write,
    output logic [abits-1:0]           o_mem_addr,
    output logic [dbits-1:0]           o_mem_wdata,
    output logic [dbits/8-1:0]         o_mem_wstrb,
    input  logic                       i_mem_ready,
    input  logic                       i_mem_resp_valid,
    input  logic [dbits-1:0]           i_mem_rdata,
    input  logic                       i_mem_err,
    output logic                       o_busy,
    output logic [$clog2(req_num)-1:0] o_grant_idx,
    output logic                       o_timeout
);

    localparam int iw = $clog2(req_num);
    localparam int sw = dbits / 8;
    localparam int ww = $clog2(timeout_cycles);

    // After reset the pointer sits on the highest index so requester 0 wins first.
    localparam logic [iw-1:0]      last_init    = iw'(req_num - 1);
    localparam logic [ww-1:0]      watchdog_max = ww'(timeout_cycles - 1);
    localparam logic [req_num-1:0] one_hot_base = req_num'(1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_t;

    state_t          state;
    logic [iw-1:0]   last;
    logic [ww-1:0]   watchdog;
    logic            win_found;
    logic [iw-1:0]   win_idx;
    logic [iw-1:0]   cand;
    logic            timeout_hit;

    logic             req_write [req_num];
    logic [abits-1:0] req_addr  [req_num];
    logic [dbits-1:0] req_wdata [req_num];
    logic [sw-1:0]    req_wstrb [req_num];

    for (genvar k = 0; k < req_num; k++) begin : g_unpack
        assign req_write[k] = i_req_write[k];
        assign req_addr[k]  = i_req_addr[k*abits +: abits];
        assign req_wdata[k] = i_req_wdata[k*dbits +: dbits];
        assign req_wstrb[k] = i_req_wstrb[k*sw +: sw];
    end

    // Pick the first valid requester after the last winner, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= req_num; i++) begin
            cand = iw'((int'(last) + i) % req_num);
            if (!win_found && i_req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Accept pulse goes out combinationally while idle so the winner sees it in its grant cycle.
    always_comb begin
        o_req_ready = '0;
        if (state == IDLE && !i_rst && win_found) begin
            o_req_ready[win_idx] = 1'b1;
        end
    end

    assign o_busy      = (state != IDLE);
    assign timeout_hit = (watchdog == watchdog_max);

    // Main controller: grant, present the request, wait for the reply or the watchdog, respond.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= IDLE;
            last         <= last_init;
            watchdog     <= '0;
            o_grant_idx  <= '0;
            o_mem_valid  <= 1'b0;
            o_mem_write  <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wdata  <= '0;
            o_mem_wstrb  <= '0;
            o_resp_valid <= '0;
            o_resp_rdata <= '0;
            o_resp_err   <= 1'b0;
            o_timeout    <= 1'b0;
        end else begin
            o_resp_valid <= '0;
            o_timeout    <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        o_mem_valid <= 1'b1;
                        o_mem_write <= req_write[win_idx];
                        o_mem_addr  <= req_addr[win_idx];
                        o_mem_wdata <= req_wdata[win_idx];
                        o_mem_wstrb <= req_wstrb[win_idx];
                        last        <= win_idx;
                        o_grant_idx <= win_idx;
                        watchdog    <= '0;
                        state       <= REQ;
                    end
                end
                REQ, RESP: begin
                    if (state == RESP && i_mem_resp_valid) begin
                        o_resp_rdata <= i_mem_rdata;
                        o_resp_err   <= i_mem_err;
                        o_resp_valid <= one_hot_base << o_grant_idx;
                        state        <= DONE;
                    end else if (timeout_hit) begin
                        o_mem_valid  <= 1'b0;
                        o_resp_rdata <= '0;
                        o_resp_err   <= 1'b1;
                        o_timeout    <= 1'b1;
                        o_resp_valid <= one_hot_base << o_grant_idx;
                        state        <= DONE;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                        if (state == REQ && i_mem_ready) begin
                            o_mem_valid <= 1'b0;
                            state       <= RESP;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter. The stimulus side
// predicts grants and responses from the round-robin and timing rules; a
// monitor compares them whenever the arbiter grants or responds.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

    localparam int NREQ  = 4;
    localparam int ABITS = 48;
    localparam int DBITS = 64;
    localparam int SBITS = DBITS / 8;
    localparam int TMO   = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_write;
    logic [NREQ*ABITS-1:0]  req_addr;
    logic [NREQ*DBITS-1:0]  req_wdata;
    logic [NREQ*SBITS-1:0]  req_wstrb;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ-1:0]        resp_valid;
    logic [DBITS-1:0]       resp_rdata;
    logic                   resp_err;
    logic                   mem_valid;
    logic                   mem_write;
    logic [ABITS-1:0]       mem_addr;
    logic [DBITS-1:0]       mem_wdata;
    logic [SBITS-1:0]       mem_wstrb;
    logic                   mem_ready;
    logic                   mem_resp_valid;
    logic [DBITS-1:0]       mem_rdata;
    logic                   mem_err;
    logic                   busy;
    logic [1:0]             grant_idx;
    logic                   timeout;

    typedef struct {
        int cyc;
        int idx;
    } grant_t;

    typedef struct {
        int               cyc;
        int               idx;
        logic [DBITS-1:0] rdata;
        logic             err;
        logic             tmo;
        int               mem_cycles;
    } resp_t;

    grant_t grant_q[$];
    resp_t  resp_q[$];

    int           cyc = 0;
    int           n_compared = 0;
    int           n_mismatched = 0;
    int           last_model = NREQ - 1;
    int           mem_count = 0;
    logic [127:0] mem_exp = '0;

    logic             f_write [NREQ];
    logic [ABITS-1:0] f_addr  [NREQ];
    logic [DBITS-1:0] f_wdata [NREQ];
    logic [SBITS-1:0] f_wstrb [NREQ];

    mem_port_arbiter #(
        .req_num        (NREQ),
        .abits          (ABITS),
        .dbits          (DBITS),
        .timeout_cycles (TMO)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req_valid      (req_valid),
        .i_req_write      (req_write),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .i_req_wstrb      (req_wstrb),
        .o_req_ready      (req_ready),
        .o_resp_valid     (resp_valid),
        .o_resp_rdata     (resp_rdata),
        .o_resp_err       (resp_err),
        .o_mem_valid      (mem_valid),
        .o_mem_write      (mem_write),
        .o_mem_addr       (mem_addr),
        .o_mem_wdata      (mem_wdata),
        .o_mem_wstrb      (mem_wstrb),
        .i_mem_ready      (mem_ready),
        .i_mem_resp_valid (mem_resp_valid),
        .i_mem_rdata      (mem_rdata),
        .i_mem_err        (mem_err),
        .o_busy           (busy),
        .o_grant_idx      (grant_idx),
        .o_timeout        (timeout)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used to timestamp grants and responses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Round-robin rule: first requesting index after the previous winner, wrapping.
    function automatic int rr_pick(input int prev, input logic [NREQ-1:0] mask);
        int c;
        for (int k = 1; k <= NREQ; k++) begin
            c = (prev + k) % NREQ;
            if (((mask >> c) & 4'd1) != 4'd0) return c;
        end
        return -1;
    endfunction

    task automatic randomize_fields();
        for (int k = 0; k < NREQ; k++) begin
            f_write[k] = 1'($urandom);
            f_addr[k]  = {16'($urandom), $urandom};
            f_wdata[k] = {$urandom, $urandom};
            f_wstrb[k] = 8'($urandom);
        end
    endtask

    task automatic drive_fields();
        for (int k = 0; k < NREQ; k++) begin
            req_write[k]                = f_write[k];
            req_addr[k*ABITS +: ABITS]  = f_addr[k];
            req_wdata[k*DBITS +: DBITS] = f_wdata[k];
            req_wstrb[k*SBITS +: SBITS] = f_wstrb[k];
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid      = '0;
            mem_ready      = 1'b0;
            mem_resp_valid = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // One access: requesters in mask ask; memory accepts after rdly wait cycles and
    // answers sdly cycles after acceptance. Expectations are queued before driving.
    task automatic apply_stimulus(input logic [NREQ-1:0] mask, input int rdly, input int sdly,
                                  input logic merr, input logic [DBITS-1:0] rd);
        int     start;
        int     pick;
        int     c;
        int     resp_rel;
        int     stop;
        logic   tmo;
        grant_t g;
        resp_t  r;
        start      = cyc;
        pick       = rr_pick(last_model, mask);
        last_model = pick;
        c          = rdly + 2 + sdly;
        tmo        = (c > TMO);
        resp_rel   = tmo ? TMO + 1 : c + 1;
        stop       = (c > resp_rel) ? c : resp_rel;
        g.cyc = start;
        g.idx = pick;
        grant_q.push_back(g);
        r.cyc        = start + resp_rel;
        r.idx        = pick;
        r.rdata      = tmo ? '0 : rd;
        r.err        = tmo ? 1'b1 : merr;
        r.tmo        = tmo;
        r.mem_cycles = (rdly + 1 < TMO) ? rdly + 1 : TMO;
        resp_q.push_back(r);
        mem_exp = {7'd0, f_write[pick], f_addr[pick], f_wdata[pick], f_wstrb[pick]};
        drive_fields();
        for (int t = 0; t <= stop; t++) begin
            req_valid      = (t <= resp_rel) ? mask : '0;
            mem_ready      = (t == rdly + 1);
            mem_resp_valid = (t == c);
            mem_rdata      = (t == c) ? rd : {$urandom, $urandom};
            mem_err        = (t == c) ? merr : 1'($urandom);
            @(posedge clk);
            #1;
        end
        req_valid      = '0;
        mem_ready      = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever the arbiter grants or responds.
    initial begin
        grant_t g;
        resp_t  r;
        forever begin
            @(negedge clk);
            if (req_ready != '0) begin
                if (grant_q.size() == 0) begin
                    check_output("grant_unexpected", 128'(req_ready), 128'(0));
                end else begin
                    g = grant_q.pop_front();
                    check_output("grant_onehot", 128'(req_ready), 128'(1) << g.idx);
                    check_output("grant_cycle", 128'(cyc), 128'(g.cyc));
                end
                mem_count = 0;
            end
            if (mem_valid) begin
                mem_count++;
                check_output("mem_fields", {7'd0, mem_write, mem_addr, mem_wdata, mem_wstrb}, mem_exp);
            end
            if (resp_valid != '0) begin
                if (resp_q.size() == 0) begin
                    check_output("resp_unexpected", 128'(resp_valid), 128'(0));
                end else begin
                    r = resp_q.pop_front();
                    check_output("resp_onehot", 128'(resp_valid), 128'(1) << r.idx);
                    check_output("resp_cycle", 128'(cyc), 128'(r.cyc));
                    check_output("resp_rdata", 128'(resp_rdata), 128'(r.rdata));
                    check_output("resp_err", 128'(resp_err), 128'(r.err));
                    check_output("resp_timeout", 128'(timeout), 128'(r.tmo));
                    check_output("grant_idx", 128'(grant_idx), 128'(r.idx));
                    check_output("mem_cycles", 128'(mem_count), 128'(r.mem_cycles));
                end
            end else if (timeout) begin
                check_output("timeout_stray", 128'(timeout), 128'(0));
            end
        end
    end

    // Stimulus sequence: reset, directed scenarios, then randomized traffic.
    initial begin
        logic [NREQ-1:0] msk;
        int              rdly;
        int              sdly;
        int              sel;
        int              pick;
        grant_t          g;

        rst            = 1'b1;
        req_valid      = '1;
        req_write      = '0;
        req_addr       = '0;
        req_wdata      = '0;
        req_wstrb      = '0;
        mem_ready      = 1'b0;
        mem_resp_valid = 1'b0;
        mem_rdata      = '0;
        mem_err        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_ready", 128'(req_ready), 128'(0));
        check_output("reset_mem", 128'({mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb}), 128'(0));
        check_output("reset_status", 128'({resp_valid, resp_rdata, resp_err, busy, grant_idx, timeout}), 128'(0));
        rst       = 1'b0;
        req_valid = '0;
        @(posedge clk);
        #1;

        // Everybody asking, zero-wait memory: 0,1,2,3,0 four cycles apart.
        for (int n = 0; n < 5; n++) begin
            randomize_fields();
            apply_stimulus(4'hF, 0, 0, 1'b0, {$urandom, $urandom});
        end
        idle_cycles(2);

        // Single read from requester 1.
        randomize_fields();
        f_write[1] = 1'b0;
        f_addr[1]  = 48'h0000_8000_0010;
        apply_stimulus(4'b0010, 0, 0, 1'b0, 64'hDEAD_BEEF_0123_4567);
        idle_cycles(1);

        // Write from requester 2 with five cycles of backpressure.
        randomize_fields();
        f_write[2] = 1'b1;
        f_wdata[2] = 64'h1122_3344_5566_7788;
        f_wstrb[2] = 8'h0F;
        apply_stimulus(4'b0100, 5, 0, 1'b0, {$urandom, $urandom});

        // Memory error, then the completion/timeout boundary, then timeouts with late replies.
        randomize_fields();
        apply_stimulus(4'b1001, 1, 1, 1'b1, {$urandom, $urandom});
        randomize_fields();
        apply_stimulus(4'b0011, 0, 14, 1'b0, {$urandom, $urandom});
        randomize_fields();
        apply_stimulus(4'b0110, 0, 15, 1'b0, {$urandom, $urandom});
        randomize_fields();
        apply_stimulus(4'b1000, 0, 20, 1'b0, {$urandom, $urandom});
        randomize_fields();
        apply_stimulus(4'b0101, 18, 0, 1'b0, {$urandom, $urandom});
        idle_cycles(1);

        // Reset while waiting for the memory reply: access abandoned, no response.
        randomize_fields();
        drive_fields();
        pick       = rr_pick(last_model, 4'hF);
        g.cyc      = cyc;
        g.idx      = pick;
        grant_q.push_back(g);
        mem_exp    = {7'd0, f_write[pick], f_addr[pick], f_wdata[pick], f_wstrb[pick]};
        req_valid  = 4'hF;
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_output("ready_in_reset", 128'(req_ready), 128'(0));
        @(posedge clk);
        #1;
        rst        = 1'b0;
        req_valid  = '0;
        last_model = NREQ - 1;
        @(negedge clk);
        check_output("midreset_mem", 128'({mem_valid, mem_write, mem_addr, mem_wdata, mem_wstrb}), 128'(0));
        check_output("midreset_status", 128'({resp_valid, resp_rdata, resp_err, busy, grant_idx, timeout}), 128'(0));
        @(posedge clk);
        #1;
        idle_cycles(2);
        randomize_fields();
        apply_stimulus(4'hF, 0, 0, 1'b0, {$urandom, $urandom});

        // Randomized traffic, occasionally slow enough to trip the watchdog.
        for (int n = 0; n < 40; n++) begin
            randomize_fields();
            msk  = 4'($urandom_range(1, 15));
            sel  = $urandom_range(0, 9);
            rdly = (sel == 0) ? $urandom_range(14, 18) : $urandom_range(0, 3);
            sdly = (sel == 1) ? $urandom_range(12, 18) : $urandom_range(0, 3);
            apply_stimulus(msk, rdly, sdly, 1'($urandom_range(0, 3) == 0), {$urandom, $urandom});
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(3);
        check_output("grant_queue_drained", 128'(grant_q.size()), 128'(0));
        check_output("resp_queue_drained", 128'(resp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
